// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg -- shared types and constants for the pipelined data memory.
//
// Contents:
//   LATENCY_MAX   largest supported accept-to-response latency
//   RSP_DATA_MAX  widest supported data word; rsp_t carries this many bits
//   rsp_t         response payload {rdata, err}; DATA_WIDTH-wide users fill the
//                 low DATA_WIDTH bits of rdata and leave the rest zero
//   be_width()    byte-enable width for a given data width
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int LATENCY_MAX  = 8;
  localparam int RSP_DATA_MAX = 256;

  typedef struct packed {
    logic [RSP_DATA_MAX-1:0] rdata;
    logic                    err;
  } rsp_t;

  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/dmem_pipe_rsp_fifo.sv
// -----------------------------------------------------------------------------
// rsp_fifo -- synchronous response FIFO, rsp_t payload, show-ahead head.
//
// Parameters:
//   DEPTH      number of entries (>= 2)
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset; empties the FIFO
//   push       write push_data (caller guarantees the FIFO is not full)
//   push_data  entry to write
//   pop        consume the head entry (ignored while empty)
//   empty      no entry available
//   head       oldest entry; stable until popped
// -----------------------------------------------------------------------------
module rsp_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  rsp_t push_data,
  input  logic pop,
  output logic empty,
  output rsp_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  rsp_t             store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && !empty;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Payload storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_data;
  end

  assign empty = (count == '0);
  assign head  = store[rd_ptr];

endmodule

// File: rtl/dmem_pipe.sv
// -----------------------------------------------------------------------------
// dmem_pipe -- data RAM with a valid/ready request channel, fixed LATENCY and
// an in-order, backpressurable response channel.
//
// Parameters: ADDR_WIDTH, DATA_WIDTH (multiple of 8), DEPTH_WORDS,
//             LATENCY (1..LATENCY_MAX), INIT_FILE.
// Ports:
//   clk, rst                      clock / synchronous active-high reset
//   req_valid, req_ready          request handshake
//   req_wen, req_addr             1 = write; byte address
//   req_byte_en, req_wdata        write lane enables and data
//   rsp_valid, rsp_ready          response handshake
//   rsp_rdata, rsp_err            read data (0 for writes/faults); fault flag
//
// Build option: define DMEM_PIPE_ERR_CHECK_EN to fault misaligned or
// out-of-range requests (rsp_err=1, rdata=0, no write). Without it the low
// address bits are ignored and the word index wraps modulo DEPTH_WORDS.
//
// The array is never cleared, not even by rst. INIT_FILE is kept so the port
// map matches the single-cycle RAM it replaces; preloading belongs to the
// memory-initialisation step of the target flow.
// -----------------------------------------------------------------------------
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int    ADDR_WIDTH  = 32,
  parameter int    DATA_WIDTH  = 32,
  parameter int    DEPTH_WORDS = 1024,
  parameter int    LATENCY     = 2,
  parameter string INIT_FILE   = "dummy.dat"
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wen,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH/8-1:0] req_byte_en,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);

  localparam int BE_W    = be_width(DATA_WIDTH);
  localparam int OFF_W   = $clog2(BE_W);
  localparam int IDX_W   = $clog2(DEPTH_WORDS);
  localparam int MAX_OUT = LATENCY + 1;
  localparam int CNT_W   = $clog2(MAX_OUT + 1);

  if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("dmem_pipe: LATENCY must be within 1..%0d", LATENCY_MAX);
  end
  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > RSP_DATA_MAX) begin : g_bad_width
    $error("dmem_pipe: DATA_WIDTH must be a multiple of 8, at most %0d", RSP_DATA_MAX);
  end

  // ---------------------------------------------------------------- decode
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [IDX_W-1:0]      idx;
  logic                  fault;
  logic                  accept;
  logic                  do_write;

  assign word_addr = req_addr >> OFF_W;
  assign idx       = IDX_W'(word_addr % ADDR_WIDTH'(DEPTH_WORDS));

`ifdef DMEM_PIPE_ERR_CHECK_EN
  assign fault = ((req_addr & ADDR_WIDTH'(BE_W - 1)) != '0) ||
                 (word_addr >= ADDR_WIDTH'(DEPTH_WORDS));
`else
  assign fault = 1'b0;
`endif

  assign accept   = req_valid && req_ready;
  assign do_write = accept && req_wen && !fault;

  // ----------------------------------------------------------------- array
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // NOTE: the array has no reset branch; committed data must survive rst and
  // a reset port would stop the tools from mapping it onto RAM.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < BE_W; b++) begin
        if (req_byte_en[b]) mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  // Only one request is accepted per edge, so a read never races a write to
  // the same edge; the read sees everything committed before it.
  rsp_t new_rsp;
  always_comb begin
    // NOTE: default every field first so no path leaves a latch behind.
    new_rsp     = '0;
    new_rsp.err = fault;
    if (!req_wen && !fault) new_rsp.rdata[DATA_WIDTH-1:0] = mem[idx];
  end

  // ----------------------------------------------------------- delay line
  // LATENCY-1 register stages; the FIFO write at edge k+LATENCY-1 makes the
  // response visible in the following cycle.
  logic push;
  rsp_t push_data;

  if (LATENCY > 1) begin : g_line
    logic vld_q [LATENCY-1];
    rsp_t rsp_q [LATENCY-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < LATENCY - 1; s++) vld_q[s] <= 1'b0;
      end else begin
        vld_q[0] <= accept;
        for (int s = 1; s < LATENCY - 1; s++) vld_q[s] <= vld_q[s-1];
      end
    end

    always_ff @(posedge clk) begin
      rsp_q[0] <= new_rsp;
      for (int s = 1; s < LATENCY - 1; s++) rsp_q[s] <= rsp_q[s-1];
    end

    assign push      = vld_q[LATENCY-2];
    assign push_data = rsp_q[LATENCY-2];
  end else begin : g_direct
    assign push      = accept;
    assign push_data = new_rsp;
  end

  // ----------------------------------------------------------- response FIFO
  logic fifo_empty;
  rsp_t head;
  logic rsp_hs;

  rsp_fifo #(.DEPTH(MAX_OUT)) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (rsp_ready),
    .empty     (fifo_empty),
    .head      (head)
  );

  assign rsp_hs    = rsp_valid && rsp_ready;
  assign rsp_valid = !fifo_empty;
  assign rsp_rdata = rsp_valid ? head.rdata[DATA_WIDTH-1:0] : '0;
  assign rsp_err   = rsp_valid && head.err;

  // ------------------------------------------------------ outstanding count
  // Counts delay-line plus FIFO occupancy, which caps the FIFO at MAX_OUT and
  // keeps rsp_ready out of the req_ready path.
  logic [CNT_W-1:0] outstanding;

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({accept, rsp_hs})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
    end
  end

  assign req_ready = !rst && (outstanding < CNT_W'(MAX_OUT));

  // Bits intentionally left unconsumed in some configurations.
  localparam bit unused_init_file = (INIT_FILE != "");
  logic unused_bits;
  assign unused_bits = ^{head, req_addr, unused_init_file};

endmodule

// File: tb/tb_dmem_pipe.sv
// -----------------------------------------------------------------------------
// tb_dmem_pipe -- self-checking bench for dmem_pipe (LATENCY=2, 1024 words).
// A queue-based model predicts req_ready, rsp_valid and every response from
// the accept/handshake rules; directed sequences add literal expectations.
// Inputs change 1 time unit after the rising edge; all sampling happens on
// the falling edge. Honours DMEM_PIPE_ERR_CHECK_EN like the design does.
// -----------------------------------------------------------------------------
module tb_dmem_pipe;

  localparam int L       = 2;
  localparam int DEPTH   = 1024;
  localparam int MAX_OUT = L + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [3:0]  req_byte_en;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  dmem_pipe #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (L),
    .INIT_FILE   ("dummy.dat")
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wen     (req_wen),
    .req_addr    (req_addr),
    .req_byte_en (req_byte_en),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------------ model
  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          due;   // first falling-edge cycle the response may be seen
  } exp_t;

  exp_t        q[$];
  logic [31:0] mdl_mem [int];

  function automatic void decode(input logic [31:0] a, output int idx, output bit fault);
    int unsigned word;
    word = a / 4;
`ifdef DMEM_PIPE_ERR_CHECK_EN
    fault = (a % 4 != 0) || (word >= DEPTH);
    idx   = fault ? 0 : int'(word);
`else
    fault = 1'b0;
    idx   = int'(word % DEPTH);
`endif
  endfunction

  always @(negedge clk) begin
    bit          exp_ready;
    bit          exp_valid;
    exp_t        e;
    int          idx;
    bit          fault;
    logic [31:0] w;
    if (cyc > 0) begin
      exp_ready = !rst && (q.size() < MAX_OUT);
      exp_valid = (q.size() > 0) && (q[0].due <= cyc);
      check("req_ready", req_ready, exp_ready);
      check("rsp_valid", rsp_valid, exp_valid);
      if (exp_valid) begin
        check("rsp_rdata", rsp_rdata, q[0].rdata);
        check("rsp_err", rsp_err, e.err | q[0].err);
      end
      if (rst) begin
        q.delete();
      end else begin
        if (exp_valid && rsp_ready) void'(q.pop_front());
        if (req_valid && exp_ready) begin
          decode(req_addr, idx, fault);
          e.err   = fault;
          e.rdata = 32'h0;
          e.due   = cyc + L;
          if (req_wen) begin
            if (!fault) begin
              w = mdl_mem.exists(idx) ? mdl_mem[idx] : 32'h0;
              for (int b = 0; b < 4; b++) if (req_byte_en[b]) w[8*b +: 8] = req_wdata[8*b +: 8];
              mdl_mem[idx] = w;
            end
          end else if (!fault) begin
            e.rdata = mdl_mem.exists(idx) ? mdl_mem[idx] : 32'hx;
          end
          q.push_back(e);
          e.err = 1'b0;
        end
      end
    end
  end

  // -------------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic req(input bit wen, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, output int acc);
    int waited;
    waited      = 0;
    req_valid   = 1'b1;
    req_wen     = wen;
    req_addr    = addr;
    req_byte_en = be;
    req_wdata   = wd;
    @(negedge clk);
    while (!req_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("req_accepted", req_ready, 1'b1);
    acc = cyc;
    step();
    req_valid = 1'b0;
  endtask

  task automatic at_cycle(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int a;
    int acc [16];

    // Reset with a write request pending: nothing accepted, outputs quiet.
    rst         = 1'b1;
    req_valid   = 1'b1;
    req_wen     = 1'b1;
    req_addr    = 32'h0;
    req_byte_en = 4'hF;
    req_wdata   = 32'hFFFF_FFFF;
    rsp_ready   = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_rsp_err", rsp_err, 1'b0);
    end
    step();
    rst       = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1'b1);
    step();

    // Byte-lane merge.
    req(1'b1, 32'h10, 4'hF, 32'h1122_3344, a);
    req(1'b1, 32'h10, 4'b0101, 32'hAABB_CCDD, a);
    req(1'b0, 32'h10, 4'h0, 32'h0, a);
    at_cycle(a + 2);
    check("bytelane_valid", rsp_valid, 1'b1);
    check("bytelane_rdata", rsp_rdata, 32'h11BB_33DD);
    check("bytelane_err", rsp_err, 1'b0);
    step();

    // Streaming: fill 16 words, then 16 back-to-back reads.
    for (int i = 0; i < 16; i++) req(1'b1, 32'h100 + 32'(4 * i), 4'hF, 32'hC0DE_0000 | 32'(i), a);
    for (int i = 0; i < 16; i++) req(1'b0, 32'h100 + 32'(4 * i), 4'h0, 32'h0, acc[i]);
    for (int i = 1; i < 16; i++) check("stream_accept_gap", 32'(acc[i] - acc[0]), 32'(i));
    at_cycle(acc[15] + 2);
    check("stream_last_rdata", rsp_rdata, 32'hC0DE_000F);
    step();

    // Backpressure: three accepts, then req_ready holds low.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) req(1'b0, 32'h100 + 32'(4 * i), 4'h0, 32'h0, acc[i]);
    check("bp_accept_gap", 32'(acc[2] - acc[0]), 32'd2);
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_addr  = 32'h10C;
    repeat (4) begin
      @(negedge clk);
      check("bp_ready_low", req_ready, 1'b0);
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_at_hs", req_ready, 1'b0);
    check("bp_first_rdata", rsp_rdata, 32'hC0DE_0000);
    @(negedge clk);
    check("bp_ready_back", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    repeat (6) step();

    // Faults / wrap-around.
    req(1'b1, 32'h0, 4'hF, 32'hCAFE_F00D, a);
    req(1'b0, 32'h12, 4'h0, 32'h0, a);
    at_cycle(a + 2);
`ifdef DMEM_PIPE_ERR_CHECK_EN
    check("misaligned_err", rsp_err, 1'b1);
    check("misaligned_rdata", rsp_rdata, 32'h0);
`else
    check("misaligned_err", rsp_err, 1'b0);
    check("misaligned_rdata", rsp_rdata, 32'h11BB_33DD);
`endif
    step();
    req(1'b1, 32'(DEPTH * 4), 4'hF, 32'hDEAD_BEEF, a);
    at_cycle(a + 2);
`ifdef DMEM_PIPE_ERR_CHECK_EN
    check("range_err", rsp_err, 1'b1);
`else
    check("range_err", rsp_err, 1'b0);
`endif
    step();
    req(1'b0, 32'h0, 4'h0, 32'h0, a);
    at_cycle(a + 2);
`ifdef DMEM_PIPE_ERR_CHECK_EN
    check("word0_after_range", rsp_rdata, 32'hCAFE_F00D);
`else
    check("word0_after_range", rsp_rdata, 32'hDEAD_BEEF);
`endif
    step();

    // Mid-flight reset: queued reads vanish, committed write survives.
    req(1'b1, 32'h20, 4'hF, 32'h5A5A_5A5A, a);
    repeat (4) step();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) req(1'b0, 32'h20, 4'h0, 32'h0, a);
    rst = 1'b1;
    step();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("flush_no_rsp", rsp_valid, 1'b0);
    end
    step();
    req(1'b0, 32'h20, 4'h0, 32'h0, a);
    at_cycle(a + 2);
    check("persist_after_rst", rsp_rdata, 32'h5A5A_5A5A);
    step();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
